pipe_stage: RTL
===============

# pipe_stage

Parametrised elastic pipeline register for the RISC-V CPU: a valid/ready stage that replaces the plain clocked register between pipeline stages. It adds backpressure (stall) and a synchronous flush that inserts a bubble. An optional two-entry skid buffer gives a fully registered `in_ready`, so no combinational path runs from `out_ready` to `in_ready`. It is instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB with per-boundary `WIDTH`.

## Interface
- `WIDTH`, 32, payload width in bits (≥1)
- `SKID`, 1, 1 = two-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`
- `clk` in 1, single clock; all state updates on its rising edge
- `reset` in 1, synchronous, active-high; sampled on the rising edge of `clk`
- `flush` in 1, synchronous; discards all held entries (bubble insertion on branch/trap)
- `in_valid` in 1, upstream has a payload
- `in_ready` out 1, stage can accept a payload this cycle
- `in_data` in `WIDTH`, upstream payload
- `out_valid` out 1, stage presents a payload
- `out_ready` in 1, downstream accepts the payload this cycle
- `out_data` out `WIDTH`, payload to downstream
- `count` out 2, number of held entries (0..2; 0..1 when `SKID`=0)

## Operation
- Accept = `in_valid && in_ready`; fire = `out_valid && out_ready`, both evaluated in the same cycle.
- Entries leave in the order they were accepted, with no loss and no duplication.
- Registers:
  - main: data plus valid, drives `out_*`.
  - skid: data plus valid, present only when `SKID`=1.
- Data registers load only on a write; `out_data` holds its value while `out_valid`=0.
- `SKID`=1 states (`count` encodes them):
  - EMPTY (0): `in_ready`=1. Accept → ONE, main←`in_data`.
  - ONE (1): `in_ready`=1.
    - Accept and fire → ONE, main←`in_data`.
    - Accept without fire → FULL, skid←`in_data`.
    - Fire without accept → EMPTY.
    - Otherwise hold.
  - FULL (2): `in_ready`=0. Fire → ONE, main←skid. Otherwise hold.
- `in_ready` (`SKID`=1) is a flop: 1 in EMPTY and ONE, 0 in FULL. It has no combinational dependence on `out_ready`.
- `SKID`=0:
  - `in_ready` = `!out_valid || out_ready` (combinational).
  - Accept loads main and sets valid; fire without accept clears valid.
- Flush (`flush`=1 at the edge):
  - All valids clear, and `count`←0.
  - Main and skid data reset to 0.
  - `in_ready`←1 (`SKID`=1).
  - A payload accepted in the flush cycle is discarded; the upstream handshake still counts as complete.
  - A fire in the flush cycle is a normal delivery.
- Priority: `reset` > `flush` > normal operation.
- `in_data` is ignored when `in_valid`=0. `out_ready` is ignored when `out_valid`=0.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `count`=0, `in_ready`=1 (`SKID`=1), internal skid valid=0, skid data=0.
- Reset mid-operation drops all entries; the first accept after reset is possible in the cycle following the reset edge.
- Latency: 1 cycle. Data accepted at edge N is on `out_data` with `out_valid`=1 after edge N.
- Throughput: 1 payload/cycle sustained whenever `out_ready`=1, in both modes.
- `SKID`=1 backpressure: `out_ready` dropping at edge N is seen by upstream as `in_ready`=0 after edge N+1 at the earliest. The one extra in-flight payload lands in skid.
- `SKID`=0 backpressure: `in_ready` follows `out_ready` in the same cycle when the stage is full.
- Simultaneous accept and fire in FULL cannot occur (`in_ready`=0).
- Simultaneous flush and accept: flush wins and the payload is dropped.

## Test plan
- Reset, then streaming: assert `reset` 2 cycles, then drive `in_data`=1..8 back-to-back with `out_ready`=1. `out_data` shows 1..8 on consecutive cycles starting 1 cycle after each accept; `count` stays 1 during the stream; `in_ready` is constantly 1.
- Skid fill (`SKID`=1): stream 0xA,0xB,0xC with `out_ready`=0 from cycle 1.
  - 0xA is in main and 0xB in skid; `count`=2; `in_ready`=0; 0xC is held upstream.
  - Raise `out_ready`: outputs 0xA, 0xB, 0xC in order.
- Random backpressure: 1000 payloads with random `in_valid`/`out_ready` (50%), both `SKID` values. The output sequence equals the input sequence exactly, and `count` never exceeds 2 (or 1 when `SKID`=0).
- Flush: in FULL holding 0x11/0x22, assert `flush` with `in_valid`=1 and `in_data`=0x33, `out_ready`=0.
  - Next cycle: `out_valid`=0, `count`=0, `in_ready`=1, `out_data`=0.
  - 0x33 never appears.
- Flush with fire: in ONE holding 0x44, assert `flush` with `out_ready`=1. 0x44 counts as delivered that cycle, and the stage is empty afterwards.
- Reset over flush: assert `reset` and `flush` together mid-stream. All outputs take their reset values, and streaming resumes correctly on the next cycle.

Source files
------------

// File: rtl/pipe_stage.sv
// pipe_stage: elastic valid/ready pipeline register with optional two-entry skid buffer and synchronous flush.
module pipe_stage #(
    parameter int WIDTH = 32,
    parameter bit SKID  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);
    logic accept, fire;
    assign accept = in_valid && in_ready;
    assign fire   = out_valid && out_ready;
    generate
        if (SKID) begin : g_skid
            logic             skid_valid, ready_q;
            logic [WIDTH-1:0] skid_data;
            // A stalled accept parks in skid; in_ready is a flop so out_ready never reaches it combinationally.
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    out_valid  <= 1'b0;
                    out_data   <= '0;
                    skid_valid <= 1'b0;
                    skid_data  <= '0;
                    ready_q    <= 1'b1;
                end else if (skid_valid) begin
                    if (out_ready) begin
                        out_data   <= skid_data;
                        skid_valid <= 1'b0;
                        ready_q    <= 1'b1;
                    end
                end else if (accept && out_valid && !out_ready) begin
                    skid_data  <= in_data;
                    skid_valid <= 1'b1;
                    ready_q    <= 1'b0;
                end else if (accept) begin
                    out_data  <= in_data;
                    out_valid <= 1'b1;
                end else if (fire) begin
                    out_valid <= 1'b0;
                end
            end
            assign in_ready = ready_q;
            assign count    = skid_valid ? 2'd2 : {1'b0, out_valid};
        end else begin : g_reg
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end else if (accept) begin
                    out_data  <= in_data;
                    out_valid <= 1'b1;
                end else if (fire) begin
                    out_valid <= 1'b0;
                end
            end
            assign in_ready = !out_valid || out_ready;
            assign count    = {1'b0, out_valid};
        end
    endgenerate
endmodule
